game_mode_seq: RTL

- Parametrised game-mode sequencer and frame-synchronous video/score selector for the Pong top level.
- Replaces the combinational menu/game/game-over mux with a debounced 4-state FSM: MENU, PLAY, PAUSE, OVER.
- Tracks the high score and auto-returns from game over after a frame count.
- Switches the displayed video source only at frame boundaries; all outputs are registered.

---
 rtl/game_mode_pkg.sv | 20 ++
 rtl/btn_debounce.sv | 50 +++++
 rtl/game_mode_seq.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/game_mode_pkg.sv
// Shared definitions for the Pong game-mode sequencer: mode encoding,
// RGB slice width helper and default timing constants.
package game_mode_pkg;

    typedef enum logic [1:0] {
        MODE_MENU  = 2'd0,
        MODE_PLAY  = 2'd1,
        MODE_PAUSE = 2'd2,
        MODE_OVER  = 2'd3
    } mode_t;

    localparam int DEF_DEBOUNCE_CYC = 1000000;
    localparam int DEF_OVER_FRAMES  = 300;
    localparam int DEF_SWITCH_TMO   = 2000000;

    function automatic int rgb_slice_w(input int color_w);
        return 3 * color_w;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stable-level down-counter and a
// single-cycle press pulse on each accepted 0->1 transition.
import game_mode_pkg::*;

module btn_debounce #(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_press
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYC - 1);

    logic [1:0]       r_sync;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             w_sync;

    assign w_sync = r_sync[1];

    // The counter only runs while the synchronised level disagrees with the
    // accepted one; any agreement reloads it, so a bounce restarts the wait.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync  <= '0;
            r_level <= 1'b0;
            r_cnt   <= CNT_LOAD;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_press <= 1'b0;
            if (w_sync == r_level) begin
                r_cnt <= CNT_LOAD;
            end else if (r_cnt == '0) begin
                r_level <= w_sync;
                r_press <= w_sync;
                r_cnt   <= CNT_LOAD;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/game_mode_seq.sv
// Pong game-mode sequencer with frame-synchronous video source selection.
// Optional macro PAUSE_DIM_EN halves RGB brightness while paused.
import game_mode_pkg::*;

module game_mode_seq #(
    parameter int COLOR_W      = 4,
    parameter int SCORE_W      = 9,
    parameter int N_SRC        = 3,
    parameter int SRC_MENU     = 0,
    parameter int SRC_PLAY     = 1,
    parameter int SRC_OVER     = 2,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int OVER_FRAMES  = DEF_OVER_FRAMES,
    parameter int SWITCH_TMO   = DEF_SWITCH_TMO
) (
    input  logic                         CLK,
    input  logic                         RST_BTN,
    input  logic                         BTNC,
    input  logic                         ENDGAME,
    input  logic [SCORE_W-1:0]           SCORE,
    input  logic [N_SRC-1:0]             SRC_HS,
    input  logic [N_SRC-1:0]             SRC_VS,
    input  logic [N_SRC*3*COLOR_W-1:0]   SRC_RGB,
    output logic                         GAME_RUN,
    output logic                         GAME_CLR,
    output logic [1:0]                   MODE,
    output logic                         VGA_HS,
    output logic                         VGA_VS,
    output logic [COLOR_W-1:0]           VGA_R,
    output logic [COLOR_W-1:0]           VGA_G,
    output logic [COLOR_W-1:0]           VGA_B,
    output logic [SCORE_W-1:0]           DISP_SCORE,
    output logic                         DISP_BLANK,
    output logic [SCORE_W-1:0]           HIGH_SCORE,
    output logic                         NEW_HIGH
);

    // state | meaning
    // MENU  | attract screen, high score shown
    // PLAY  | game core running, live score shown
    // PAUSE | game core frozen, live score shown
    // OVER  | final score latched, display blanked, auto-return after frames

    localparam int RGB_W = rgb_slice_w(COLOR_W);
    localparam int SRC_W = $clog2(N_SRC);
    localparam int FRM_W = (OVER_FRAMES > 1) ? $clog2(OVER_FRAMES) : 1;
    localparam int TMO_W = (SWITCH_TMO > 1) ? $clog2(SWITCH_TMO) : 1;
    localparam logic [FRM_W-1:0] FRM_LOAD = FRM_W'(OVER_FRAMES - 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(SWITCH_TMO - 1);
    localparam logic [SRC_W-1:0] S_MENU = SRC_W'(SRC_MENU);
    localparam logic [SRC_W-1:0] S_PLAY = SRC_W'(SRC_PLAY);
    localparam logic [SRC_W-1:0] S_OVER = SRC_W'(SRC_OVER);

    mode_t              r_mode, w_mode_nxt;
    logic               w_press;
    logic [SRC_W-1:0]   r_disp_src, w_tgt_src;
    logic [N_SRC-1:0]   r_vs_d;
    logic               w_frame;
    logic [FRM_W-1:0]   r_frm_cnt;
    logic [TMO_W-1:0]   r_tmo;
    logic [SCORE_W-1:0] r_high, r_final, w_high_nxt, w_final_nxt;
    logic               r_new_high, w_new_high_nxt;
    logic               r_game_run, r_game_clr, r_disp_blank;
    logic [SCORE_W-1:0] r_disp_score;
    logic               r_vga_hs, r_vga_vs, w_hs, w_vs;
    logic [RGB_W-1:0]   r_rgb, w_rgb, w_rgb_out;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btnc (
        .i_clk   (CLK),
        .i_rst_n (RST_BTN),
        .i_btn   (BTNC),
        .o_press (w_press)
    );

    always_comb begin
        w_hs    = 1'b1;
        w_vs    = 1'b1;
        w_rgb   = '0;
        w_frame = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (r_disp_src == SRC_W'(i)) begin
                w_hs    = SRC_HS[i];
                w_vs    = SRC_VS[i];
                w_rgb   = SRC_RGB[i*RGB_W +: RGB_W];
                w_frame = r_vs_d[i] & ~SRC_VS[i];
            end
        end
    end

    always_comb begin
        w_rgb_out = w_rgb;
`ifdef PAUSE_DIM_EN
        if (r_mode == MODE_PAUSE) begin
            w_rgb_out = {w_rgb[RGB_W-1 -: COLOR_W] >> 1,
                         w_rgb[2*COLOR_W-1 -: COLOR_W] >> 1,
                         w_rgb[COLOR_W-1:0] >> 1};
        end
`endif
    end

    always_comb begin
        w_tgt_src = S_MENU;
        case (r_mode)
            MODE_PLAY, MODE_PAUSE: w_tgt_src = S_PLAY;
            MODE_OVER:             w_tgt_src = S_OVER;
            default:               w_tgt_src = S_MENU;
        endcase
    end

    always_comb begin
        w_mode_nxt     = r_mode;
        w_high_nxt     = r_high;
        w_final_nxt    = r_final;
        w_new_high_nxt = r_new_high;
        case (r_mode)
            MODE_MENU: begin
                if (w_press) begin
                    w_mode_nxt     = MODE_PLAY;
                    w_new_high_nxt = 1'b0;
                end
            end
            MODE_PLAY: begin
                // ENDGAME takes priority over a coincident press.
                if (ENDGAME) begin
                    w_mode_nxt     = MODE_OVER;
                    w_final_nxt    = SCORE;
                    w_new_high_nxt = (SCORE > r_high);
                    if (SCORE > r_high) w_high_nxt = SCORE;
                end else if (w_press) begin
                    w_mode_nxt = MODE_PAUSE;
                end
            end
            MODE_PAUSE: begin
                if (w_press) w_mode_nxt = MODE_PLAY;
            end
            MODE_OVER: begin
                if (w_press || (w_frame && r_frm_cnt == '0)) w_mode_nxt = MODE_MENU;
            end
            default: w_mode_nxt = MODE_MENU;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_BTN) begin
            r_mode       <= MODE_MENU;
            r_high       <= '0;
            r_final      <= '0;
            r_new_high   <= 1'b0;
            r_game_run   <= 1'b0;
            r_game_clr   <= 1'b0;
            r_disp_blank <= 1'b0;
            r_disp_score <= '0;
        end else begin
            r_mode       <= w_mode_nxt;
            r_high       <= w_high_nxt;
            r_final      <= w_final_nxt;
            r_new_high   <= w_new_high_nxt;
            r_game_run   <= (w_mode_nxt == MODE_PLAY);
            r_game_clr   <= (r_mode == MODE_MENU) && (w_mode_nxt == MODE_PLAY);
            r_disp_blank <= (w_mode_nxt == MODE_OVER);
            case (w_mode_nxt)
                MODE_MENU: r_disp_score <= w_high_nxt;
                MODE_OVER: r_disp_score <= w_final_nxt;
                default:   r_disp_score <= SCORE;
            endcase
        end
    end

    // Source switch waits for a VS fall on the shown source; the timeout
    // down-counter only runs while a switch is pending.
    always_ff @(posedge CLK) begin
        if (!RST_BTN) begin
            r_vs_d     <= '0;
            r_disp_src <= S_MENU;
            r_tmo      <= TMO_LOAD;
            r_frm_cnt  <= FRM_LOAD;
            r_vga_hs   <= 1'b1;
            r_vga_vs   <= 1'b1;
            r_rgb      <= '0;
        end else begin
            r_vs_d   <= SRC_VS;
            r_vga_hs <= w_hs;
            r_vga_vs <= w_vs;
            r_rgb    <= w_rgb_out;
            if (r_mode != MODE_OVER) begin
                r_frm_cnt <= FRM_LOAD;
            end else if (w_frame && r_frm_cnt != '0) begin
                r_frm_cnt <= r_frm_cnt - 1'b1;
            end
            if (r_disp_src == w_tgt_src) begin
                r_tmo <= TMO_LOAD;
            end else if (w_frame || r_tmo == '0) begin
                r_disp_src <= w_tgt_src;
                r_tmo      <= TMO_LOAD;
            end else begin
                r_tmo <= r_tmo - 1'b1;
            end
        end
    end

    assign MODE       = r_mode;
    assign GAME_RUN   = r_game_run;
    assign GAME_CLR   = r_game_clr;
    assign DISP_SCORE = r_disp_score;
    assign DISP_BLANK = r_disp_blank;
    assign HIGH_SCORE = r_high;
    assign NEW_HIGH   = r_new_high;
    assign VGA_HS     = r_vga_hs;
    assign VGA_VS     = r_vga_vs;
    assign VGA_R      = r_rgb[RGB_W-1 -: COLOR_W];
    assign VGA_G      = r_rgb[2*COLOR_W-1 -: COLOR_W];
    assign VGA_B      = r_rgb[COLOR_W-1:0];

endmodule
